// File: rtl/parking_allocator.sv
// Four-slot parking allocator: edge-detects entry/exit sensor levels, queues
// one pending request of each kind, and drives one barrier at a time with a
// per-gate timeout that rolls back an entry allocation if the car never passes.
module parking_allocator #(
  parameter int GATE_TIMEOUT = 8
) (
  input  logic       slow_clk_1,
  input  logic       rst,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  input  logic       gate_clear,
  output logic [3:0] occupancy,
  output logic [2:0] free_count,
  output logic       full,
  output logic [1:0] assign_slot,
  output logic       entry_gate_open,
  output logic       exit_gate_open,
  output logic       err_exit_empty
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_t;

  // Timer value on the last cycle a gate may stay open.
  localparam logic [3:0] TIMEOUT_LAST = 4'(GATE_TIMEOUT - 1);

  state_t     state;
  logic       entry_q;
  logic       exit_q;
  logic       pend_entry;
  logic       pend_exit;
  logic [3:0] timer;
  logic       entry_edge;
  logic       exit_edge;
  logic [1:0] free_slot;

  // Lowest-index clear bit; only meaningful when at least one bit is clear.
  function automatic logic [1:0] lowest_free(input logic [3:0] occ);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!occ[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Number of clear bits in the occupancy map.
  function automatic logic [2:0] count_free(input logic [3:0] occ);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, ~occ[i]};
    end
    return cnt;
  endfunction

  assign entry_edge = entry_req & ~entry_q;
  assign exit_edge  = exit_req & ~exit_q;
  assign free_slot  = lowest_free(occupancy);
  assign free_count = count_free(occupancy);
  assign full       = (occupancy == 4'b1111);

  // Request capture, gate FSM, slot bookkeeping and registered outputs.
  always_ff @(posedge slow_clk_1 or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      entry_q         <= 1'b0;
      exit_q          <= 1'b0;
      pend_entry      <= 1'b0;
      pend_exit       <= 1'b0;
      timer           <= 4'd0;
      occupancy       <= 4'b0000;
      assign_slot     <= 2'd0;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      err_exit_empty  <= 1'b0;
    end else begin
      entry_q        <= entry_req;
      exit_q         <= exit_req;
      err_exit_empty <= 1'b0;
      // Edges only set a flag; an edge while the flag is already set is lost.
      if (entry_edge) pend_entry <= 1'b1;
      if (exit_edge)  pend_exit  <= 1'b1;

      case (state)
        IDLE: begin
          // Exit is checked first so a departing car can make room.
          if (pend_exit) begin
            pend_exit <= 1'b0;
            if (occupancy[exit_slot]) begin
              occupancy[exit_slot] <= 1'b0;
              state                <= EXIT_OPEN;
              exit_gate_open       <= 1'b1;
              timer                <= 4'd0;
            end else begin
              err_exit_empty <= 1'b1;
            end
          end else if (pend_entry && !full) begin
            pend_entry             <= 1'b0;
            occupancy[free_slot]   <= 1'b1;
            assign_slot            <= free_slot;
            state                  <= ENTRY_OPEN;
            entry_gate_open        <= 1'b1;
            timer                  <= 4'd0;
          end
        end

        ENTRY_OPEN: begin
          if (gate_clear || timer == TIMEOUT_LAST) begin
            // Car never passed: hand the reserved slot back.
            if (!gate_clear) occupancy[assign_slot] <= 1'b0;
            state           <= IDLE;
            entry_gate_open <= 1'b0;
            timer           <= 4'd0;
          end else begin
            timer <= timer + 4'd1;
          end
        end

        EXIT_OPEN: begin
          if (gate_clear || timer == TIMEOUT_LAST) begin
            state          <= IDLE;
            exit_gate_open <= 1'b0;
            timer          <= 4'd0;
          end else begin
            timer <= timer + 4'd1;
          end
        end

        default: begin
          state           <= IDLE;
          entry_gate_open <= 1'b0;
          exit_gate_open  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_allocator.sv
// Directed bench for parking_allocator. Inputs change on the falling edge and
// outputs are sampled on the falling edge, midway between active edges.
module tb_parking_allocator;

  logic       slow_clk_1;
  logic       rst;
  logic       entry_req;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic       gate_clear;
  logic [3:0] occupancy;
  logic [2:0] free_count;
  logic       full;
  logic [1:0] assign_slot;
  logic       entry_gate_open;
  logic       exit_gate_open;
  logic       err_exit_empty;

  int checks;
  int errors;

  parking_allocator #(.GATE_TIMEOUT(8)) dut (
    .slow_clk_1      (slow_clk_1),
    .rst             (rst),
    .entry_req       (entry_req),
    .exit_req        (exit_req),
    .exit_slot       (exit_slot),
    .gate_clear      (gate_clear),
    .occupancy       (occupancy),
    .free_count      (free_count),
    .full            (full),
    .assign_slot     (assign_slot),
    .entry_gate_open (entry_gate_open),
    .exit_gate_open  (exit_gate_open),
    .err_exit_empty  (err_exit_empty)
  );

  initial slow_clk_1 = 1'b0;
  always #5 slow_clk_1 = ~slow_clk_1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge slow_clk_1);
  endtask

  // Stimulus helper: one car enters and clears the gate on its first open cycle.
  task automatic park_one();
    entry_req = 1'b1;
    tick();
    tick();
    gate_clear = 1'b1;
    entry_req  = 1'b0;
    tick();
    gate_clear = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    exit_slot  = 2'd0;
    gate_clear = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({occupancy, free_count, full, assign_slot, entry_gate_open, exit_gate_open, err_exit_empty}
        !== {4'b0000, 3'd4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: occ=%b free=%0d full=%b slot=%0d eg=%b xg=%b err=%b, want 0000/4/0/0/0/0/0",
               occupancy, free_count, full, assign_slot, entry_gate_open, exit_gate_open, err_exit_empty);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_entry();
    entry_req = 1'b1;
    tick();
    checks++;
    if (entry_gate_open !== 1'b0) begin
      errors++;
      $display("FAIL entry_latency: gate=%b after first edge, want 0", entry_gate_open);
    end
    tick();
    checks++;
    if ({entry_gate_open, occupancy, assign_slot, free_count} !== {1'b1, 4'b0001, 2'd0, 3'd3}) begin
      errors++;
      $display("FAIL entry_grant: gate=%b occ=%b slot=%0d free=%0d, want 1/0001/0/3",
               entry_gate_open, occupancy, assign_slot, free_count);
    end
    entry_req = 1'b0;
    tick();
    checks++;
    if (entry_gate_open !== 1'b1) begin
      errors++;
      $display("FAIL entry_gate_cycle2: gate=%b, want 1", entry_gate_open);
    end
    gate_clear = 1'b1;
    tick();
    gate_clear = 1'b0;
    checks++;
    if ({entry_gate_open, occupancy, free_count} !== {1'b0, 4'b0001, 3'd3}) begin
      errors++;
      $display("FAIL entry_close: gate=%b occ=%b free=%0d, want 0/0001/3",
               entry_gate_open, occupancy, free_count);
    end
    // gate_clear in IDLE must be ignored.
    gate_clear = 1'b1;
    tick();
    gate_clear = 1'b0;
    checks++;
    if ({occupancy, entry_gate_open, exit_gate_open} !== {4'b0001, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL idle_gate_clear: occ=%b eg=%b xg=%b, want 0001/0/0",
               occupancy, entry_gate_open, exit_gate_open);
    end
  endtask

  task automatic test_full_then_exit();
    park_one();
    park_one();
    park_one();
    checks++;
    if ({occupancy, full, free_count, assign_slot} !== {4'b1111, 1'b1, 3'd0, 2'd3}) begin
      errors++;
      $display("FAIL fill: occ=%b full=%b free=%0d slot=%0d, want 1111/1/0/3",
               occupancy, full, free_count, assign_slot);
    end
    entry_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (entry_gate_open !== 1'b0 || exit_gate_open !== 1'b0) begin
        errors++;
        $display("FAIL full_blocks_entry: eg=%b xg=%b cycle %0d, want 0/0", entry_gate_open, exit_gate_open, i);
      end
    end
    exit_slot = 2'd2;
    exit_req  = 1'b1;
    tick();
    tick();
    checks++;
    if ({exit_gate_open, entry_gate_open, occupancy, full} !== {1'b1, 1'b0, 4'b1011, 1'b0}) begin
      errors++;
      $display("FAIL exit_grant: xg=%b eg=%b occ=%b full=%b, want 1/0/1011/0",
               exit_gate_open, entry_gate_open, occupancy, full);
    end
    gate_clear = 1'b1;
    exit_req   = 1'b0;
    tick();
    gate_clear = 1'b0;
    checks++;
    if (exit_gate_open !== 1'b0 || entry_gate_open !== 1'b0) begin
      errors++;
      $display("FAIL exit_close: xg=%b eg=%b, want 0/0", exit_gate_open, entry_gate_open);
    end
    tick();
    checks++;
    if ({entry_gate_open, assign_slot, occupancy} !== {1'b1, 2'd2, 4'b1111}) begin
      errors++;
      $display("FAIL pending_entry_served: eg=%b slot=%0d occ=%b, want 1/2/1111",
               entry_gate_open, assign_slot, occupancy);
    end
    gate_clear = 1'b1;
    entry_req  = 1'b0;
    tick();
    gate_clear = 1'b0;
    tick();
  endtask

  task automatic test_exit_priority();
    apply_reset();
    park_one();
    park_one();
    checks++;
    if (occupancy !== 4'b0011) begin
      errors++;
      $display("FAIL prio_setup: occ=%b, want 0011", occupancy);
    end
    exit_slot = 2'd1;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    tick();
    tick();
    checks++;
    if ({exit_gate_open, entry_gate_open, occupancy} !== {1'b1, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL prio_exit_first: xg=%b eg=%b occ=%b, want 1/0/0001",
               exit_gate_open, entry_gate_open, occupancy);
    end
    gate_clear = 1'b1;
    exit_req   = 1'b0;
    entry_req  = 1'b0;
    tick();
    gate_clear = 1'b0;
    tick();
    checks++;
    if ({entry_gate_open, exit_gate_open, assign_slot, occupancy} !== {1'b1, 1'b0, 2'd1, 4'b0011}) begin
      errors++;
      $display("FAIL prio_entry_second: eg=%b xg=%b slot=%0d occ=%b, want 1/0/1/0011",
               entry_gate_open, exit_gate_open, assign_slot, occupancy);
    end
    gate_clear = 1'b1;
    tick();
    gate_clear = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int open_cycles;
    open_cycles = 0;
    entry_req = 1'b1;
    tick();
    tick();
    checks++;
    if ({entry_gate_open, assign_slot, occupancy} !== {1'b1, 2'd2, 4'b0111}) begin
      errors++;
      $display("FAIL timeout_grant: eg=%b slot=%0d occ=%b, want 1/2/0111",
               entry_gate_open, assign_slot, occupancy);
    end
    entry_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (entry_gate_open === 1'b1) open_cycles++;
      tick();
    end
    checks++;
    if (open_cycles != 8) begin
      errors++;
      $display("FAIL timeout_length: open %0d cycles, want 8", open_cycles);
    end
    checks++;
    if ({occupancy, entry_gate_open} !== {4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL timeout_rollback: occ=%b eg=%b, want 0011/0", occupancy, entry_gate_open);
    end
  endtask

  task automatic test_exit_empty();
    apply_reset();
    exit_slot = 2'd3;
    exit_req  = 1'b1;
    tick();
    tick();
    checks++;
    if ({err_exit_empty, exit_gate_open, occupancy} !== {1'b1, 1'b0, 4'b0000}) begin
      errors++;
      $display("FAIL exit_empty_pulse: err=%b xg=%b occ=%b, want 1/0/0000",
               err_exit_empty, exit_gate_open, occupancy);
    end
    exit_req = 1'b0;
    tick();
    checks++;
    if ({err_exit_empty, exit_gate_open} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exit_empty_once: err=%b xg=%b, want 0/0", err_exit_empty, exit_gate_open);
    end
  endtask

  task automatic test_reset_mid_gate();
    entry_req = 1'b1;
    tick();
    tick();
    checks++;
    if (entry_gate_open !== 1'b1) begin
      errors++;
      $display("FAIL midgate_setup: eg=%b, want 1", entry_gate_open);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({entry_gate_open, exit_gate_open, occupancy, free_count, full} !== {1'b0, 1'b0, 4'b0000, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: eg=%b xg=%b occ=%b free=%0d full=%b, want 0/0/0000/4/0",
               entry_gate_open, exit_gate_open, occupancy, free_count, full);
    end
    // entry_req stays high across reset release and must count as a new edge.
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({entry_gate_open, assign_slot, occupancy} !== {1'b1, 2'd0, 4'b0001}) begin
      errors++;
      $display("FAIL level_after_reset: eg=%b slot=%0d occ=%b, want 1/0/0001",
               entry_gate_open, assign_slot, occupancy);
    end
    entry_req  = 1'b0;
    gate_clear = 1'b1;
    tick();
    gate_clear = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    entry_req  = 1'b0;
    exit_req   = 1'b0;
    exit_slot  = 2'd0;
    gate_clear = 1'b0;
    test_reset();
    test_single_entry();
    test_full_then_exit();
    test_exit_priority();
    test_timeout();
    test_exit_empty();
    test_reset_mid_gate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_allocator.md
PARKING_ALLOCATOR -- requirements
Module: parking_allocator

Interface
REQ-001 SHALL have parameter GATE_TIMEOUT, default 8, meaning the number of slow_clk_1 cycles a gate stays open without gate_clear before forced close (legal range 2..15).
REQ-002 SHALL have port slow_clk_1  input  1  block clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port entry_req  input  1  level from the entry car sensor.
REQ-005 SHALL have port exit_req  input  1  level from the exit car sensor.
REQ-006 SHALL have port exit_slot  input  2  index of the slot being vacated, sampled at exit grant.
REQ-007 SHALL have port gate_clear  input  1  car has passed the currently open gate.
REQ-008 SHALL have port occupancy  output  4  per-slot occupied bits, bit i = slot i; the bitmap drives the availability LEDs and the four slot switches.
REQ-009 SHALL have port free_count  output  3  number of free slots, 0..4.
REQ-010 SHALL have port full  output  1  high when occupancy == 4'b1111.
REQ-011 SHALL have port assign_slot  output  2  slot allocated to the car currently entering.
REQ-012 SHALL have port entry_gate_open  output  1  entry barrier command.
REQ-013 SHALL have port exit_gate_open  output  1  exit barrier command.
REQ-014 SHALL have port err_exit_empty  output  1  one-cycle pulse when an exit names a slot that is already free.

Function
REQ-015 SHALL register entry_req and exit_req and detect rising edges (current high, previous low).
REQ-016 SHALL set pend_entry or pend_exit on the corresponding rising edge, and hold the flag until that request is served; further edges while a flag is set have no effect.
REQ-017 SHALL implement FSM states IDLE, ENTRY_OPEN and EXIT_OPEN, with IDLE as the reset state.
REQ-018 SHALL, in IDLE with pend_exit set, grant the exit: clear pend_exit and move to EXIT_OPEN.
REQ-019 SHALL, in IDLE with pend_exit clear, pend_entry set and full low, grant the entry: clear pend_entry and move to ENTRY_OPEN.
REQ-020 SHALL give exit priority over entry when both flags are pending in the same cycle.
REQ-021 SHALL keep pend_entry set while full is high, with no gate opening; the entry is served on the first IDLE cycle after a slot frees.
REQ-022 SHALL, on entry grant, allocate the lowest-index free slot, set its occupancy bit and load assign_slot in the same edge.
REQ-023 SHALL, on exit grant with occupancy[exit_slot]==1, clear that bit in the same edge.
REQ-024 SHALL, on exit grant with occupancy[exit_slot]==0, stay in IDLE, pulse err_exit_empty for one cycle and leave occupancy unchanged; pend_exit is still cleared.
REQ-025 SHALL drive entry_gate_open high exactly while in ENTRY_OPEN and exit_gate_open high exactly while in EXIT_OPEN; the two are never high together.
REQ-026 SHALL load a 4-bit timer with 0 on entering either OPEN state and increment it each cycle in that state.
REQ-027 SHALL leave an OPEN state for IDLE on gate_clear, or when the timer reaches GATE_TIMEOUT-1, whichever comes first.
REQ-028 SHALL, on an ENTRY_OPEN timeout without gate_clear, roll back by clearing occupancy[assign_slot]; an exit timeout does not restore the bit.
REQ-029 SHALL ignore gate_clear while in IDLE.
REQ-030 SHALL compute free_count and full combinationally from occupancy.
REQ-031 SHALL make a grant from IDLE at the earliest one cycle after the rising edge of the request is sampled.

Reset
REQ-032 SHALL, on rst asserted at any time including mid-gate, force state=IDLE, occupancy=0, pend flags=0, timer=0, assign_slot=0, both gate outputs=0, err_exit_empty=0 and the edge-detect registers=0; outputs then read free_count=4 and full=0.
REQ-033 SHALL resume normal operation on the first rising edge of slow_clk_1 after rst deasserts; a request level already high at that point counts as a rising edge.

Verification
REQ-034 SHALL be verified by this scenario: from reset, entry_req edge then gate_clear two cycles later -> occupancy=0001, assign_slot=0, entry_gate_open high for 2 cycles, free_count=3.
REQ-035 SHALL be verified by this scenario: fill all 4 slots, then an entry edge -> full=1, no gate opens; then exit with exit_slot=2 and gate_clear -> the pending entry is granted, assign_slot=2, occupancy=1111.
REQ-036 SHALL be verified by this scenario: entry and exit edges in the same cycle with occupancy=0011 and exit_slot=1 -> exit served first (occupancy=0001), then entry, which takes slot 1 (occupancy=0011).
REQ-037 SHALL be verified by this scenario: entry granted and no gate_clear -> gate closes after exactly GATE_TIMEOUT=8 cycles and occupancy returns to its prior value.
REQ-038 SHALL be verified by this scenario: exit with exit_slot=3 while occupancy=0000 -> err_exit_empty high for 1 cycle, exit_gate_open stays 0.
REQ-039 SHALL be verified by this scenario: rst asserted during ENTRY_OPEN -> gate outputs drop asynchronously, occupancy=0000, state=IDLE.
